conv_window_bram: RTL
=====================

CONV_WINDOW_BRAM -- requirements
Module: conv_window_bram

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the pixel width in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 6, meaning the memory address width; depth is 2^ADDR_WIDTH.
REQ-003 The module SHALL have parameter KERNEL, default 3, meaning the window side K; K read ports exist.
REQ-004 The module SHALL have parameter IMG_W, default 6, meaning the image width in pixels.
REQ-005 The module SHALL have parameter IMG_H, default 6, meaning the image height in pixels.
REQ-006 The legal parameter range SHALL be 1<=KERNEL<=IMG_W, KERNEL<=IMG_H and IMG_W*IMG_H<=2^ADDR_WIDTH; anything outside it is unsupported.
REQ-007 i_clk  input  1  single clock; all state is updated on its rising edge.
REQ-008 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-009 i_wr_en  input  1  write strobe.
REQ-010 i_w_addr  input  ADDR_WIDTH  write address; the image is stored row-major, pixel (r,c) at r*IMG_W+c.
REQ-011 i_data  input  DATA_WIDTH  write data.
REQ-012 i_start  input  1  starts a full window sweep.
REQ-013 i_ready  input  1  consumer accepts the current window.
REQ-014 o_busy  output  1  high in every state except IDLE.
REQ-015 o_valid  output  1  o_window holds a complete window.
REQ-016 o_window  output  KERNEL*KERNEL*DATA_WIDTH  window data; element (r,c) is at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the top row and c=0 the leftmost column.
REQ-017 o_row, o_col  output  ADDR_WIDTH each  top-left image coordinate of the current window.
REQ-018 o_done  output  1  one-cycle pulse after the last window is accepted.

Function
REQ-019 The memory SHALL have one synchronous write port and K synchronous read ports; read data SHALL appear 1 cycle after the address is issued.
REQ-020 A write SHALL occur only when i_wr_en=1 in IDLE; i_wr_en SHALL be ignored while o_busy=1.
REQ-021 The FSM SHALL have the states IDLE, FETCH, OUT and DONE.
REQ-022 IDLE->FETCH SHALL occur when i_start=1; i_start SHALL be ignored in all other states.
REQ-023 If i_start=1 and i_wr_en=1 in the same IDLE cycle, the write SHALL commit and subsequent fetches SHALL see the new data.
REQ-024 FETCH SHALL last exactly K+1 cycles, counted with step s=0..K:
- For s<K, read port j SHALL be issued address (o_row+s)*IMG_W+o_col+j.
- For s>=1, the returned row s-1 SHALL be captured into window row s-1.
REQ-025 FETCH->OUT SHALL occur after step s=K; in OUT, o_valid=1 and o_window, o_row and o_col SHALL be held stable until i_ready=1.
REQ-026 On a cycle in OUT with i_ready=1, the window SHALL be accepted and the position advanced:
- If o_col<IMG_W-K, o_col+1.
- Otherwise o_col=0 and o_row+1.
- The FSM SHALL then return to FETCH.
REQ-027 Accepting the window at (IMG_H-K, IMG_W-K) SHALL move the FSM to DONE instead of advancing.
REQ-028 In DONE, o_done=1 for exactly one cycle, then the FSM SHALL go to IDLE with o_row=o_col=0.
REQ-029 A sweep SHALL produce exactly (IMG_W-K+1)*(IMG_H-K+1) windows, stride 1, in raster order.
REQ-030 First o_valid SHALL occur K+2 cycles after the edge that samples i_start; with i_ready held high, one window SHALL be produced every K+2 cycles.
REQ-031 o_valid SHALL be 0 in every state other than OUT.

Reset
REQ-032 While i_rst_n=0, asynchronously: the FSM SHALL be in IDLE, and o_busy, o_valid, o_done, o_row, o_col, o_window and the step counter SHALL all be 0.
REQ-033 The memory array SHALL NOT be reset, and its contents SHALL be retained across reset.
REQ-034 A reset asserted mid-sweep SHALL abort the sweep; after reset a new i_start SHALL begin again at (0,0).

Verification (defaults: K=3, 6x6, mem[a]=a+1 for a=0..35)
REQ-035 Load, then pulse i_start with i_ready=1 -> o_valid at cycle 5 after start, first window {1,2,3,7,8,9,13,14,15}, o_row=o_col=0.
REQ-036 Full sweep with i_ready=1 -> 16 windows, every o_valid 5 cycles apart, second window at (0,1)={2,3,4,8,9,10,14,15,16}, last at (3,3)={22,23,24,28,29,30,34,35,36}, o_done one cycle after the last accept.
REQ-037 Backpressure: i_ready=0 for 6 cycles while in OUT -> o_valid stays 1, o_window/o_row/o_col unchanged; the window is accepted on the cycle i_ready returns to 1.
REQ-038 i_wr_en=1 with i_w_addr=0 and i_data=8'hFF during a sweep -> ignored; the next sweep's first window still has element (0,0)=1.
REQ-039 i_rst_n low during FETCH of window 4 -> all outputs 0 immediately; a new i_start replays from window {1,2,3,...}, showing memory was retained.
REQ-040 i_start held high through an entire sweep -> exactly one sweep occurs; a new sweep starts only if i_start is high in IDLE.

Source files
------------

// File: rtl/conv_window_bram_if.sv
// Handshake/bus bundle for conv_window_bram: pixel write port, sweep control and window output.
interface conv_window_bram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int KERNEL     = 3
);
    logic                                 i_wr_en;
    logic [ADDR_WIDTH-1:0]                i_w_addr;
    logic [DATA_WIDTH-1:0]                i_data;
    logic                                 i_start;
    logic                                 i_ready;
    logic                                 o_busy;
    logic                                 o_valid;
    logic                                 o_done;
    logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  o_window;
    logic [ADDR_WIDTH-1:0]                o_row;
    logic [ADDR_WIDTH-1:0]                o_col;

    modport master (
        output i_wr_en, i_w_addr, i_data, i_start, i_ready,
        input  o_busy, o_valid, o_done, o_window, o_row, o_col
    );

    modport slave (
        input  i_wr_en, i_w_addr, i_data, i_start, i_ready,
        output o_busy, o_valid, o_done, o_window, o_row, o_col
    );
endinterface

// File: rtl/conv_window_bram.sv
// KxK sliding-window fetcher over a row-major image in a 1W/KR memory.
// Each read lane j owns window column j; rows are fetched one per cycle.
module conv_window_bram_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int KERNEL     = 3,
    parameter int SW         = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              cap_en,
    input  logic [SW-1:0]                     cap_row,
    input  logic [DATA_WIDTH-1:0]             rd_data,
    output logic [KERNEL-1:0][DATA_WIDTH-1:0] col_q
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q <= '0;
        end else if (cap_en) begin
            for (int r = 0; r < KERNEL; r++)
                if (cap_row == SW'(r)) col_q[r] <= rd_data;
        end
    end
endmodule

module conv_window_bram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int KERNEL     = 3,
    parameter int IMG_W      = 6,
    parameter int IMG_H      = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    conv_window_bram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int SW    = $clog2(KERNEL + 1);
    localparam logic [ADDR_WIDTH-1:0] IMG_W_A  = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(IMG_H - KERNEL);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_W - KERNEL);

    typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} state_t;

    state_t                state;
    logic [SW-1:0]         step;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  rd_en;
    logic                  cap_en;
    logic [SW-1:0]         cap_row;

    // Step K issues no read; it only captures the last row returned.
    assign rd_en   = (state == FETCH) && (step != SW'(KERNEL));
    assign cap_en  = (state == FETCH) && (step != '0);
    assign cap_row = step - 1'b1;

    // Memory contents survive reset, so this block has no reset branch.
    always_ff @(posedge i_clk) begin
        if (state == IDLE && bus.i_wr_en) mem[bus.i_w_addr] <= bus.i_data;
    end

    for (genvar j = 0; j < KERNEL; j++) begin : g_lane
        logic [ADDR_WIDTH-1:0]             rd_addr;
        logic [DATA_WIDTH-1:0]             rd_q;
        logic [KERNEL-1:0][DATA_WIDTH-1:0] col_q;

        assign rd_addr = (bus.o_row + ADDR_WIDTH'(step)) * IMG_W_A + bus.o_col + ADDR_WIDTH'(j);

        always_ff @(posedge i_clk) begin
            if (rd_en) rd_q <= mem[rd_addr];
        end

        conv_window_bram_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .KERNEL     (KERNEL),
            .SW         (SW)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .cap_en  (cap_en),
            .cap_row (cap_row),
            .rd_data (rd_q),
            .col_q   (col_q)
        );

        for (genvar r = 0; r < KERNEL; r++) begin : g_row
            assign bus.o_window[(r*KERNEL+j)*DATA_WIDTH +: DATA_WIDTH] = col_q[r];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            step        <= '0;
            bus.o_busy  <= 1'b0;
            bus.o_valid <= 1'b0;
            bus.o_done  <= 1'b0;
            bus.o_row   <= '0;
            bus.o_col   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state      <= FETCH;
                        step       <= '0;
                        bus.o_busy <= 1'b1;
                    end
                end
                FETCH: begin
                    if (step == SW'(KERNEL)) begin
                        state       <= OUT;
                        step        <= '0;
                        bus.o_valid <= 1'b1;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.i_ready) begin
                        bus.o_valid <= 1'b0;
                        if (bus.o_row == LAST_ROW && bus.o_col == LAST_COL) begin
                            state      <= DONE;
                            bus.o_done <= 1'b1;
                        end else begin
                            state <= FETCH;
                            if (bus.o_col < LAST_COL) begin
                                bus.o_col <= bus.o_col + 1'b1;
                            end else begin
                                bus.o_col <= '0;
                                bus.o_row <= bus.o_row + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    bus.o_done <= 1'b0;
                    bus.o_busy <= 1'b0;
                    bus.o_row  <= '0;
                    bus.o_col  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
